kb_ascii_decoder: RTL and testbench

Stateful PS/2 set-2 keyboard decoder: consumes the raw received byte stream, tracks prefixes (E0/F0) and modifier state (Shift, Ctrl, CapsLock), and emits translated ASCII characters through a buffered valid/ready output. It sits between the PS/2 byte receiver and the character consumers (UART TX, text display), replacing the bare combinational scancode lookup at that point.

---
 rtl/kb_pkg.sv | 123 ++++++++++++
 rtl/kb_char_fifo.sv | 49 ++++
 rtl/kb_ascii_decoder.sv | 170 +++++++++++++++++
 tb/tb_kb_ascii_decoder.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kb_pkg.sv
// kb_pkg: shared constants, prefix FSM states and the
// set-2 scancode to ASCII translation (JIS layout).
package kb_pkg;

    localparam logic [7:0] KB_E0     = 8'hE0;
    localparam logic [7:0] KB_F0     = 8'hF0;
    localparam logic [7:0] KB_LSHIFT = 8'h12;
    localparam logic [7:0] KB_RSHIFT = 8'h59;
    localparam logic [7:0] KB_CTRL   = 8'h14;
    localparam logic [7:0] KB_CAPS   = 8'h58;
    localparam logic [7:0] KB_NONE   = 8'hFF;

    localparam int NUM_STATUS = 6;
    localparam logic [7:0] KB_STATUS [NUM_STATUS] = '{
        8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BRK,
        ST_EXT,
        ST_EXT_BRK
    } kb_state_t;

    function automatic logic is_status(input logic [7:0] code);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_STATUS; i++) begin
            if (code == KB_STATUS[i]) hit = 1'b1;
        end
        return hit;
    endfunction

    // Lower-case letter for a scancode, FF if not a letter.
    function automatic logic [7:0] letter_of(input logic [7:0] code);
        logic [7:0] c;
        case (code)
            8'h1C: c = "a";
            8'h32: c = "b";
            8'h21: c = "c";
            8'h23: c = "d";
            8'h24: c = "e";
            8'h2B: c = "f";
            8'h34: c = "g";
            8'h33: c = "h";
            8'h43: c = "i";
            8'h3B: c = "j";
            8'h42: c = "k";
            8'h4B: c = "l";
            8'h3A: c = "m";
            8'h31: c = "n";
            8'h44: c = "o";
            8'h4D: c = "p";
            8'h15: c = "q";
            8'h2D: c = "r";
            8'h1B: c = "s";
            8'h2C: c = "t";
            8'h3C: c = "u";
            8'h2A: c = "v";
            8'h1D: c = "w";
            8'h22: c = "x";
            8'h35: c = "y";
            8'h1A: c = "z";
            default: c = KB_NONE;
        endcase
        return c;
    endfunction

    function automatic logic is_letter(input logic [7:0] code);
        return letter_of(code) != KB_NONE;
    endfunction

    // {unshifted, shifted} for digits, symbols and control keys.
    function automatic logic [15:0] symbol_of(input logic [7:0] code);
        logic [15:0] p;
        case (code)
            8'h16: p = {8'h31, 8'h21};
            8'h1E: p = {8'h32, 8'h22};
            8'h26: p = {8'h33, 8'h23};
            8'h25: p = {8'h34, 8'h24};
            8'h2E: p = {8'h35, 8'h25};
            8'h36: p = {8'h36, 8'h26};
            8'h3D: p = {8'h37, 8'h27};
            8'h3E: p = {8'h38, 8'h28};
            8'h46: p = {8'h39, 8'h29};
            8'h45: p = {8'h30, KB_NONE};
            8'h4E: p = {8'h2D, 8'h3D};
            8'h55: p = {8'h5E, 8'h7E};
            8'h6A: p = {8'h5C, 8'h7C};
            8'h54: p = {8'h40, 8'h60};
            8'h5B: p = {8'h5B, 8'h7B};
            8'h4C: p = {8'h3B, 8'h2B};
            8'h52: p = {8'h3A, 8'h2A};
            8'h5D: p = {8'h5D, 8'h7D};
            8'h41: p = {8'h2C, 8'h3C};
            8'h49: p = {8'h2E, 8'h3E};
            8'h4A: p = {8'h2F, 8'h3F};
            8'h51: p = {8'h5C, 8'h5F};
            8'h29: p = {8'h20, 8'h20};
            8'h5A: p = {8'h0D, 8'h0D};
            8'h66: p = {8'h08, 8'h08};
            8'h0D: p = {8'h09, 8'h09};
            8'h76: p = {8'h1B, 8'h1B};
            default: p = {KB_NONE, KB_NONE};
        endcase
        return p;
    endfunction

    // Letters take case from camel, everything else from shift.
    function automatic logic [7:0] ascii(
        input logic [7:0] code,
        input logic       camel,
        input logic       shift
    );
        logic [7:0]  l;
        logic [15:0] p;
        l = letter_of(code);
        p = symbol_of(code);
        if (l != KB_NONE) return camel ? (l - 8'h20) : l;
        return shift ? p[7:0] : p[15:8];
    endfunction

endpackage

// File: rtl/kb_char_fifo.sv
// kb_char_fifo: first-word-fall-through character queue.
// Extra pointer bit separates full from empty.
module kb_char_fifo
    import kb_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [7:0]  mem [DEPTH];
    logic        do_pop;
    logic        do_push;

    assign empty   = wr_ptr == rd_ptr;
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

    // Advance pointers on accepted push and pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset; empty masks stale data.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/kb_ascii_decoder.sv
// kb_ascii_decoder: PS/2 set-2 byte stream to ASCII with
// prefix tracking, modifiers, repeat filter and output FIFO.
module kb_ascii_decoder
    import kb_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter bit REPEAT_EN = 1'b1,
    parameter bit CTRL_EN   = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [7:0] i_scancode,
    input  logic       i_valid,
    output logic [7:0] o_ascii,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_shift,
    output logic       o_capslock,
    output logic       o_overflow
);

    kb_state_t  state;
    logic       l_shift, r_shift, l_ctrl, r_ctrl;
    logic       caps, caps_held;
    logic       lm_vld;
    logic [8:0] lm_key;
    logic       ch_vld;
    logic [7:0] ch_data;

    logic       in_ext, in_brk;
    logic       is_stat, is_e0, is_f0;
    logic       key_evt, make_evt, brk_evt;
    logic [8:0] key;
    logic       rpt_hit, is_mod;
    logic       shift, ctrl;
    logic [7:0] xl;
    logic       emit;

    logic       fifo_full, fifo_empty, pop;

    // Classify the incoming byte and translate it.
    always_comb begin
        in_ext   = (state == ST_EXT) || (state == ST_EXT_BRK);
        in_brk   = (state == ST_BRK) || (state == ST_EXT_BRK);
        is_stat  = is_status(i_scancode);
        is_e0    = i_scancode == KB_E0;
        is_f0    = (i_scancode == KB_F0) && (state != ST_EXT_BRK);
        key_evt  = i_valid && !is_stat && !is_e0 && !is_f0;
        make_evt = key_evt && !in_brk;
        brk_evt  = key_evt && in_brk;
        key      = {in_ext, i_scancode};
        rpt_hit  = !REPEAT_EN && lm_vld && (lm_key == key);
        is_mod   = (i_scancode == KB_CTRL) ||
                   (!in_ext && ((i_scancode == KB_LSHIFT) ||
                                (i_scancode == KB_RSHIFT) ||
                                (i_scancode == KB_CAPS)));
        shift    = l_shift | r_shift;
        ctrl     = l_ctrl | r_ctrl;
        if (in_ext) begin
            if (i_scancode == 8'h5A)      xl = 8'h0D;
            else if (i_scancode == 8'h4A) xl = 8'h2F;
            else                          xl = KB_NONE;
        end else if (CTRL_EN && ctrl && is_letter(i_scancode)) begin
            xl = ascii(i_scancode, 1'b0, 1'b0) & 8'h1F;
        end else begin
            xl = ascii(i_scancode, shift ^ caps, shift);
        end
        emit = make_evt && !rpt_hit && !is_mod && (xl != KB_NONE);
    end

    // Prefix FSM: E0 / F0 tracking, status bytes resync.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= ST_IDLE;
        end else if (i_valid) begin
            if (is_stat) begin
                state <= ST_IDLE;
            end else if (is_e0) begin
                state <= ST_EXT;
            end else begin
                unique case (state)
                    ST_IDLE: state <= is_f0 ? ST_BRK : ST_IDLE;
                    ST_EXT:  state <= is_f0 ? ST_EXT_BRK : ST_IDLE;
                    ST_BRK:  state <= is_f0 ? ST_BRK : ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // Modifier held bits and the CapsLock latch.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            l_shift   <= 1'b0;
            r_shift   <= 1'b0;
            l_ctrl    <= 1'b0;
            r_ctrl    <= 1'b0;
            caps      <= 1'b0;
            caps_held <= 1'b0;
        end else if (make_evt) begin
            if (!in_ext && i_scancode == KB_LSHIFT) l_shift <= 1'b1;
            if (!in_ext && i_scancode == KB_RSHIFT) r_shift <= 1'b1;
            if (i_scancode == KB_CTRL) begin
                if (in_ext) r_ctrl <= 1'b1;
                else        l_ctrl <= 1'b1;
            end
            if (!in_ext && i_scancode == KB_CAPS) begin
                caps_held <= 1'b1;
                if (!caps_held) caps <= !caps;
            end
        end else if (brk_evt) begin
            if (!in_ext && i_scancode == KB_LSHIFT) l_shift <= 1'b0;
            if (!in_ext && i_scancode == KB_RSHIFT) r_shift <= 1'b0;
            if (i_scancode == KB_CTRL) begin
                if (in_ext) r_ctrl <= 1'b0;
                else        l_ctrl <= 1'b0;
            end
            if (!in_ext && i_scancode == KB_CAPS) caps_held <= 1'b0;
        end
    end

    // Remember the last held make so typematic repeats can be dropped.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            lm_vld <= 1'b0;
            lm_key <= '0;
        end else if (make_evt && !rpt_hit) begin
            lm_vld <= 1'b1;
            lm_key <= key;
        end else if (brk_evt && lm_vld && (lm_key == key)) begin
            lm_vld <= 1'b0;
        end
    end

    // Translate register feeding the FIFO one cycle later.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ch_vld  <= 1'b0;
            ch_data <= '0;
        end else begin
            ch_vld <= emit;
            if (emit) ch_data <= xl;
        end
    end

    // Flag a character lost to a full FIFO.
    always_ff @(posedge i_clk) begin
        if (i_reset) o_overflow <= 1'b0;
        else         o_overflow <= ch_vld && fifo_full && !pop;
    end

    assign pop        = i_ready && !fifo_empty;
    assign o_valid    = !fifo_empty;
    assign o_shift    = l_shift | r_shift;
    assign o_capslock = caps;

    kb_char_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (i_clk),
        .rst   (i_reset),
        .push  (ch_vld),
        .din   (ch_data),
        .pop   (pop),
        .dout  (o_ascii),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_kb_ascii_decoder.sv
// tb_kb_ascii_decoder: two decoder configurations driven with the
// same byte stream and checked every cycle against a keyboard model.
module tb_kb_ascii_decoder;

    logic       i_clk;
    logic       i_reset;
    logic [7:0] i_scancode;
    logic       i_valid;
    logic       i_ready;

    logic [7:0] a_ascii, b_ascii;
    logic       a_valid, b_valid;
    logic       a_shift, b_shift;
    logic       a_caps, b_caps;
    logic       a_ovf, b_ovf;

    int n_cmp = 0;
    int n_bad = 0;
    bit armed = 0;

    kb_ascii_decoder u_a (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_scancode (i_scancode),
        .i_valid    (i_valid),
        .o_ascii    (a_ascii),
        .o_valid    (a_valid),
        .i_ready    (i_ready),
        .o_shift    (a_shift),
        .o_capslock (a_caps),
        .o_overflow (a_ovf)
    );

    kb_ascii_decoder #(
        .DEPTH     (4),
        .REPEAT_EN (1'b0),
        .CTRL_EN   (1'b1)
    ) u_b (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_scancode (i_scancode),
        .i_valid    (i_valid),
        .o_ascii    (b_ascii),
        .o_valid    (b_valid),
        .i_ready    (i_ready),
        .o_shift    (b_shift),
        .o_capslock (b_caps),
        .o_overflow (b_ovf)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // ---------------- key tables ----------------
    logic [7:0] t_lo [256];
    logic [7:0] t_hi [256];
    bit         t_let [256];

    localparam logic [7:0] LETTERS [26] = '{
        8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
        8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
        8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A
    };
    localparam logic [7:0] DIGITS [10] = '{
        8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46
    };
    localparam logic [7:0] POOL [30] = '{
        8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h1C, 8'h16, 8'h1E, 8'h45,
        8'h29, 8'h5A, 8'h4A, 8'h4E, 8'h66, 8'h12, 8'h59, 8'h14, 8'h58,
        8'h12, 8'hE0, 8'hE0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hAA, 8'hFA,
        8'h05, 8'h75, 8'h3A
    };

    initial begin
        for (int i = 0; i < 256; i++) begin
            t_lo[i] = 8'hFF;
            t_hi[i] = 8'hFF;
            t_let[i] = 0;
        end
        for (int i = 0; i < 26; i++) begin
            t_lo[LETTERS[i]] = 8'h61 + 8'(i);
            t_hi[LETTERS[i]] = 8'h41 + 8'(i);
            t_let[LETTERS[i]] = 1;
        end
        for (int i = 0; i < 10; i++) begin
            t_lo[DIGITS[i]] = 8'h30 + 8'(i);
            t_hi[DIGITS[i]] = (i == 0) ? 8'hFF : 8'h20 + 8'(i);
        end
        t_lo[8'h29] = 8'h20; t_hi[8'h29] = 8'h20;
        t_lo[8'h5A] = 8'h0D; t_hi[8'h5A] = 8'h0D;
        t_lo[8'h66] = 8'h08; t_hi[8'h66] = 8'h08;
        t_lo[8'h4A] = 8'h2F; t_hi[8'h4A] = 8'h3F;
        t_lo[8'h4E] = 8'h2D; t_hi[8'h4E] = 8'h3D;
    end

    // ---------------- keyboard model ----------------
    bit         m_ext [2], m_brk [2];
    bit         m_ls [2], m_rs [2], m_lc [2], m_rc [2];
    bit         m_caps [2], m_caps_h [2];
    bit         m_lmv [2];
    logic [8:0] m_lm [2];
    bit         m_pv [2];
    logic [7:0] m_pc [2];
    logic [7:0] mbuf [2][8];
    int         mcnt [2];
    bit         m_ovf [2];

    function automatic logic [7:0] xlate(int k, bit e, logic [7:0] b);
        bit sh;
        sh = m_ls[k] | m_rs[k];
        if (e) return (b == 8'h5A) ? 8'h0D : (b == 8'h4A) ? 8'h2F : 8'hFF;
        if (t_let[b]) begin
            if (m_lc[k] | m_rc[k]) return t_lo[b] & 8'h1F;
            return (sh ^ m_caps[k]) ? t_hi[b] : t_lo[b];
        end
        return sh ? t_hi[b] : t_lo[b];
    endfunction

    task automatic key_down(int k, bit e, logic [7:0] b);
        logic [7:0] c;
        if (k == 1) begin
            if (m_lmv[k] && m_lm[k] == {e, b}) return;
            m_lmv[k] = 1;
            m_lm[k] = {e, b};
        end
        if (b == 8'h14) begin
            if (e) m_rc[k] = 1; else m_lc[k] = 1;
            return;
        end
        if (!e && b == 8'h12) begin m_ls[k] = 1; return; end
        if (!e && b == 8'h59) begin m_rs[k] = 1; return; end
        if (!e && b == 8'h58) begin
            if (!m_caps_h[k]) m_caps[k] = !m_caps[k];
            m_caps_h[k] = 1;
            return;
        end
        c = xlate(k, e, b);
        if (c != 8'hFF) begin
            m_pv[k] = 1;
            m_pc[k] = c;
        end
    endtask

    task automatic key_up(int k, bit e, logic [7:0] b);
        if (k == 1 && m_lmv[k] && m_lm[k] == {e, b}) m_lmv[k] = 0;
        if (b == 8'h14) begin
            if (e) m_rc[k] = 0; else m_lc[k] = 0;
        end
        if (!e && b == 8'h12) m_ls[k] = 0;
        if (!e && b == 8'h59) m_rs[k] = 0;
        if (!e && b == 8'h58) m_caps_h[k] = 0;
    endtask

    task automatic decode(int k, logic [7:0] b);
        bit e, br;
        if (b == 8'hAA || b == 8'hFA || b == 8'hFE || b == 8'hEE ||
            b == 8'h00 || b == 8'hFF) begin
            m_ext[k] = 0; m_brk[k] = 0;
            return;
        end
        if (b == 8'hE0) begin
            m_ext[k] = 1; m_brk[k] = 0;
            return;
        end
        if (b == 8'hF0 && !(m_brk[k] && m_ext[k])) begin
            m_brk[k] = 1;
            return;
        end
        e = m_ext[k]; br = m_brk[k];
        m_ext[k] = 0; m_brk[k] = 0;
        if (br) key_up(k, e, b);
        else    key_down(k, e, b);
    endtask

    task automatic model_step(int k);
        int dep;
        bit full, popd;
        dep = (k == 0) ? 8 : 4;
        if (i_reset) begin
            m_ext[k] = 0; m_brk[k] = 0;
            m_ls[k] = 0; m_rs[k] = 0; m_lc[k] = 0; m_rc[k] = 0;
            m_caps[k] = 0; m_caps_h[k] = 0; m_lmv[k] = 0; m_lm[k] = '0;
            m_pv[k] = 0; mcnt[k] = 0; m_ovf[k] = 0;
            return;
        end
        full = mcnt[k] == dep;
        popd = (mcnt[k] > 0) && i_ready;
        if (popd) begin
            for (int j = 0; j < 7; j++) mbuf[k][j] = mbuf[k][j+1];
            mcnt[k]--;
        end
        m_ovf[k] = 0;
        if (m_pv[k]) begin
            if (full && !popd) m_ovf[k] = 1;
            else begin
                mbuf[k][mcnt[k]] = m_pc[k];
                mcnt[k]++;
            end
        end
        m_pv[k] = 0;
        if (i_valid) decode(k, i_scancode);
    endtask

    always @(posedge i_clk) begin
        model_step(0);
        model_step(1);
    end

    // ---------------- checking ----------------
    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    logic [7:0] log_a [$];
    logic [7:0] log_b [$];
    logic [7:0] want [$];
    int ov_a = 0;
    int ov_b = 0;

    always @(negedge i_clk) begin
        if (armed) begin
            chk("a_valid", a_valid, mcnt[0] != 0);
            if (mcnt[0] != 0) chk("a_ascii", a_ascii, mbuf[0][0]);
            chk("a_shift", a_shift, m_ls[0] | m_rs[0]);
            chk("a_caps", a_caps, m_caps[0]);
            chk("a_ovf", a_ovf, m_ovf[0]);
            chk("b_valid", b_valid, mcnt[1] != 0);
            if (mcnt[1] != 0) chk("b_ascii", b_ascii, mbuf[1][0]);
            chk("b_shift", b_shift, m_ls[1] | m_rs[1]);
            chk("b_caps", b_caps, m_caps[1]);
            chk("b_ovf", b_ovf, m_ovf[1]);
            if (a_valid && i_ready) log_a.push_back(a_ascii);
            if (b_valid && i_ready) log_b.push_back(b_ascii);
            if (a_ovf) ov_a++;
            if (b_ovf) ov_b++;
        end
    end

    task automatic check_log(string nm, int k);
        logic [7:0] got [$];
        if (k == 0) got = log_a;
        else        got = log_b;
        chk({nm, "_count"}, got.size(), want.size());
        for (int i = 0; i < want.size() && i < got.size(); i++)
            chk(nm, got[i], want[i]);
    endtask

    task automatic clear_logs();
        log_a.delete();
        log_b.delete();
    endtask

    task automatic send(input logic [7:0] b);
        i_scancode = b;
        i_valid = 1'b1;
        @(negedge i_clk);
        i_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        @(negedge i_clk);
        i_reset = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit fast;
        i_reset = 1'b1;
        i_valid = 1'b0;
        i_scancode = 8'h00;
        i_ready = 1'b0;
        idle(2);
        armed = 1;
        chk("rst_a_valid", a_valid, 0);
        chk("rst_a_ascii", a_ascii, 8'h00);
        chk("rst_a_shift", a_shift, 0);
        chk("rst_a_caps", a_caps, 0);
        chk("rst_a_ovf", a_ovf, 0);
        chk("rst_b_valid", b_valid, 0);
        i_reset = 1'b0;

        // two-cycle latency of a plain make
        send(8'h1C);
        chk("lat_early", a_valid, 0);
        @(negedge i_clk);
        chk("lat_valid", a_valid, 1);
        chk("lat_ascii", a_ascii, 8'h61);
        i_ready = 1'b1;
        idle(4);

        clear_logs();
        send(8'h1C); send(8'hF0); send(8'h1C);
        idle(5);
        want = '{8'h61};
        check_log("break_silent", 0);

        clear_logs();
        send(8'h12);
        chk("shift_held", a_shift, 1);
        send(8'h1C); send(8'h16); send(8'hF0); send(8'h12);
        chk("shift_released", a_shift, 0);
        send(8'h1C);
        idle(5);
        want = '{8'h41, 8'h21, 8'h61};
        check_log("shift_seq", 0);

        clear_logs();
        send(8'h58); send(8'hF0); send(8'h58);
        chk("caps_on", a_caps, 1);
        send(8'h1C); send(8'h12); send(8'h1C); send(8'h16);
        send(8'hF0); send(8'h12);
        send(8'h58); send(8'hF0); send(8'h58);
        chk("caps_off", a_caps, 0);
        idle(5);
        want = '{8'h41, 8'h61, 8'h21};
        check_log("caps_seq", 0);

        clear_logs();
        send(8'h14); send(8'h1C); send(8'hF0); send(8'h14); send(8'h1C);
        send(8'hE0); send(8'h5A);
        send(8'hE0); send(8'h75);
        send(8'hE0); send(8'hF0); send(8'h5A);
        send(8'hE0); send(8'hAA); send(8'h1C);
        idle(6);
        want = '{8'h01, 8'h61, 8'h0D, 8'h61};
        check_log("ctrl_ext_seq", 0);

        send(8'hF0); send(8'h1C);
        idle(3);
        clear_logs();
        send(8'h1C); send(8'h1C); send(8'h1C);
        send(8'hF0); send(8'h1C); send(8'h1C);
        idle(6);
        want = '{8'h61, 8'h61, 8'h61, 8'h61};
        check_log("repeat_on", 0);
        want = '{8'h61, 8'h61};
        check_log("repeat_off", 1);

        // overflow on the depth-4 instance
        i_ready = 1'b0;
        do_reset();
        ov_a = 0;
        ov_b = 0;
        send(8'h1C); send(8'h32); send(8'h21);
        send(8'h23); send(8'h24); send(8'h2B);
        idle(3);
        chk("ovf_b_count", ov_b, 2);
        chk("ovf_a_count", ov_a, 0);
        chk("ovf_b_valid", b_valid, 1);
        send(8'h34);
        i_ready = 1'b1;
        @(negedge i_clk);
        i_ready = 1'b0;
        idle(2);
        chk("pushpop_no_ovf", ov_b, 2);

        send(8'hE0);
        do_reset();
        chk("rst_mid_a_valid", a_valid, 0);
        chk("rst_mid_b_valid", b_valid, 0);
        clear_logs();
        i_ready = 1'b1;
        send(8'h1C);
        idle(4);
        want = '{8'h61};
        check_log("rst_mid_a", 0);
        check_log("rst_mid_b", 1);
        clear_logs();
        send(8'hE0);
        do_reset();
        send(8'h5A);
        idle(4);
        want = '{8'h0D};
        check_log("rst_mid_5a", 1);

        // random traffic against the model
        fast = 1;
        for (int i = 0; i < 4000; i++) begin
            i_reset = ($urandom_range(0, 799) == 0);
            i_valid = ($urandom_range(0, 9) < 6);
            i_scancode = POOL[$urandom_range(0, 29)];
            if ($urandom_range(0, 19) == 0) fast = !fast;
            i_ready = fast ? ($urandom_range(0, 3) != 0)
                           : ($urandom_range(0, 7) == 0);
            @(negedge i_clk);
        end
        i_reset = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        idle(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
